// File: rtl/serial_tx.sv
// Transmit half of the 8051 serial port (modes 1, 2, 3): serialises SBUF writes onto TXD
// and raises TI on entry to the stop bit.
module serial_tx #(
    parameter int M2_DIV = 64,
    parameter int T_DIV  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       t_o,
    input  logic [1:0] sm,
    input  logic       smod,
    input  logic       tb8,
    input  logic       sbuf_wr,
    input  logic [7:0] sbuf_wdata,
    input  logic       clr_ti,
    output logic       txd,
    output logic       ti,
    output logic       tx_busy
);

    localparam int MAX_DIV = (M2_DIV > T_DIV) ? M2_DIV : T_DIV;
    localparam int PW      = $clog2(MAX_DIV + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_BIT9,
        S_STOP
    } state_e;

    state_e          state_q;
    logic [7:0]      data_q;
    logic            tb8_q;
    logic            nine_q;
    logic            clk_baud_q;
    logic            smod_q;
    logic [PW-1:0]   presc_q;
    logic [PW-1:0]   presc_d;
    logic [2:0]      idx_q;
    logic            txd_q;
    logic            ti_q;
    logic            busy_q;

    logic            baud_ev;
    logic            tick;
    logic            accept;
    logic            ti_set;
    logic [PW-1:0]   limit;
    logic [2:0]      idx_nxt;

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        limit   = '0;
        presc_d = presc_q;
        if (clk_baud_q) begin
            limit = smod_q ? PW'(M2_DIV / 2) : PW'(M2_DIV);
        end else begin
            limit = smod_q ? PW'(T_DIV / 2) : PW'(T_DIV);
        end

        // The bit clock only runs during a frame, so t_o while idle is ignored.
        baud_ev = (state_q != S_IDLE) && (clk_baud_q || t_o);
        tick    = baud_ev && (presc_q == limit - PW'(1));
        if (baud_ev) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        idx_nxt = idx_q + 3'd1;
        ti_set  = tick && (((state_q == S_DATA) && (idx_q == 3'd7) && !nine_q) ||
                           (state_q == S_BIT9));
        // A new byte may start on the very tick that ends the stop bit.
        accept  = sbuf_wr && (sm != 2'd0) &&
                  ((state_q == S_IDLE) || ((state_q == S_STOP) && tick));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            tb8_q      <= 1'b0;
            nine_q     <= 1'b0;
            clk_baud_q <= 1'b0;
            smod_q     <= 1'b0;
            presc_q    <= '0;
            idx_q      <= '0;
            txd_q      <= 1'b1;
            ti_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            if (ti_set) begin
                ti_q <= 1'b1;
            end else if (clr_ti) begin
                ti_q <= 1'b0;
            end

            if (accept) begin
                data_q     <= sbuf_wdata;
                tb8_q      <= tb8;
                nine_q     <= sm[1];
                clk_baud_q <= (sm == 2'd2);
                smod_q     <= smod;
                presc_q    <= '0;
                idx_q      <= '0;
                state_q    <= S_START;
                txd_q      <= 1'b0;
                busy_q     <= 1'b1;
            end else begin
                presc_q <= presc_d;
                case (state_q)
                    S_IDLE: begin
                        txd_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end
                    S_START: begin
                        if (tick) begin
                            state_q <= S_DATA;
                            idx_q   <= '0;
                            txd_q   <= data_q[0];
                        end
                    end
                    S_DATA: begin
                        if (tick) begin
                            if (idx_q == 3'd7) begin
                                state_q <= nine_q ? S_BIT9 : S_STOP;
                                txd_q   <= nine_q ? tb8_q : 1'b1;
                            end else begin
                                idx_q <= idx_nxt;
                                txd_q <= data_q[idx_nxt];
                            end
                        end
                    end
                    S_BIT9: begin
                        if (tick) begin
                            state_q <= S_STOP;
                            txd_q   <= 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (tick) begin
                            state_q <= S_IDLE;
                            txd_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        txd_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign txd     = txd_q;
    assign ti      = ti_q;
    assign tx_busy = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: directed frames plus random traffic checked every
// cycle against a frame-level model (bit index = baud events since accept / divider).
module tb_serial_tx;

    localparam int M2_DIV = 64;
    localparam int T_DIV  = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       t_o = 1'b0;
    logic [1:0] sm = 2'd0;
    logic       smod = 1'b0;
    logic       tb8 = 1'b0;
    logic       sbuf_wr = 1'b0;
    logic [7:0] sbuf_wdata = 8'h00;
    logic       clr_ti = 1'b0;
    logic       txd;
    logic       ti;
    logic       tx_busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit m_busy = 1'b0;
    bit m_ti = 1'b0;
    bit m_use_clk = 1'b0;
    int m_cnt = 0;
    int m_div = 1;
    int m_nbits = 10;
    bit m_bits [0:10];

    serial_tx #(.M2_DIV(M2_DIV), .T_DIV(T_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .t_o        (t_o),
        .sm         (sm),
        .smod       (smod),
        .tb8        (tb8),
        .sbuf_wr    (sbuf_wr),
        .sbuf_wdata (sbuf_wdata),
        .clr_ti     (clr_ti),
        .txd        (txd),
        .ti         (ti),
        .tx_busy    (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ev_now();
        return m_busy && (m_use_clk || t_o);
    endfunction

    function automatic bit will_end();
        return m_busy && ((m_cnt + int'(ev_now())) / m_div >= m_nbits);
    endfunction

    function automatic bit will_set();
        return ev_now() && ((m_cnt + 1) / m_div == m_nbits - 1) && (m_cnt / m_div < m_nbits - 1);
    endfunction

    task automatic model_accept();
        m_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) m_bits[i+1] = sbuf_wdata[i];
        if (sm[1]) begin
            m_bits[9]  = tb8;
            m_bits[10] = 1'b1;
            m_nbits    = 11;
        end else begin
            m_bits[9] = 1'b1;
            m_nbits   = 10;
        end
        m_use_clk = (sm == 2'd2);
        if (sm == 2'd2) m_div = smod ? M2_DIV / 2 : M2_DIV;
        else            m_div = smod ? T_DIV / 2 : T_DIV;
        m_cnt  = 0;
        m_busy = 1'b1;
    endtask

    task automatic model_step();
        bit ends;
        bit sets;
        ends = will_end();
        sets = will_set();
        if (ev_now()) m_cnt++;
        if (ends) m_busy = 1'b0;
        if (!m_busy && sbuf_wr && sm != 2'd0) model_accept();
        if (sets) m_ti = 1'b1;
        else if (clr_ti) m_ti = 1'b0;
    endtask

    task automatic do_cycle();
        @(posedge clk);
        model_step();
        #1;
        check("txd", txd, m_busy ? m_bits[m_cnt / m_div] : 1'b1);
        check("tx_busy", tx_busy, m_busy);
        check("ti", ti, m_ti);
    endtask

    // Runs the current frame to completion; k counts edges with the accept edge as 1.
    task automatic run_frame(input bit rnd_to, output int ti_at, output int idle_at);
        ti_at   = 0;
        idle_at = 0;
        for (int k = 2; k <= 3000 && m_busy; k++) begin
            if (rnd_to) t_o = 1'($urandom);
            do_cycle();
            if (ti === 1'b1 && ti_at == 0) ti_at = k;
            if (tx_busy === 1'b0 && idle_at == 0) idle_at = k;
        end
        if (m_busy) check("frame_timeout", tx_busy, 0);
    endtask

    initial begin
        logic [9:0] t1_exp;
        int ti_at;
        int idle_at;
        int n;

        // Reset values
        #12;
        check("rst_txd", txd, 1);
        check("rst_ti", ti, 0);
        check("rst_busy", tx_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mode 1, smod=1, t_o every clk, 0xA5; busy write at 44; clr_ti coincident with set, then later
        t1_exp = 10'b1101001010;
        sm = 2'd1; smod = 1'b1; tb8 = 1'b0; t_o = 1'b1;
        sbuf_wdata = 8'hA5; sbuf_wr = 1'b1;
        do_cycle();
        sbuf_wr = 1'b0;
        ti_at = 0; idle_at = 0;
        for (int k = 2; k <= 200; k++) begin
            sbuf_wr    = (k == 44);
            sbuf_wdata = (k == 44) ? 8'h55 : 8'hA5;
            clr_ti     = (k == 145) || (k == 170);
            do_cycle();
            if (ti === 1'b1 && ti_at == 0) ti_at = k;
            if (tx_busy === 1'b0 && idle_at == 0) idle_at = k;
            if (k >= 9 && (k - 9) % 16 == 0 && (k - 9) / 16 < 10)
                check("t1_txd_bit", txd, t1_exp[(k - 9) / 16]);
            if (k == 146) check("t4_ti_set_dominant", ti, 1);
        end
        sbuf_wr = 1'b0; clr_ti = 1'b0;
        check("t1_ti_clk", ti_at, 145);
        check("t1_busy_clk", idle_at, 161);
        check("t4_ti_cleared", ti, 0);

        // Mode 3, smod=0, tb8=1, 0x3C, then back-to-back 0x81 on the stop tick
        sm = 2'd3; smod = 1'b0; tb8 = 1'b1; t_o = 1'b1;
        sbuf_wdata = 8'h3C; sbuf_wr = 1'b1;
        do_cycle();
        sbuf_wr = 1'b0;
        n = 0;
        while (!will_end() && n < 1000) begin
            do_cycle();
            n++;
        end
        check("t2_frame_clks", n + 1, 11 * 32);
        sbuf_wdata = 8'h81; sbuf_wr = 1'b1;
        do_cycle();
        sbuf_wr = 1'b0;
        check("b2b_busy", tx_busy, 1);
        check("b2b_start_bit", txd, 0);
        run_frame(1'b0, ti_at, idle_at);

        // Mode 2, smod=0, 0xFF, tb8=0 so the 9th bit is visible; t_o random and ignored
        sm = 2'd2; smod = 1'b0; tb8 = 1'b0;
        sbuf_wdata = 8'hFF; sbuf_wr = 1'b1; clr_ti = 1'b1;
        do_cycle();
        sbuf_wr = 1'b0; clr_ti = 1'b0;
        run_frame(1'b1, ti_at, idle_at);
        check("t3_ti_clk", ti_at, 1 + 10 * 64);
        check("t3_busy_clk", idle_at, 1 + 11 * 64);

        // Reset during data bit 3, then a full 0x81 frame
        sm = 2'd1; smod = 1'b1; t_o = 1'b1;
        sbuf_wdata = 8'hA5; sbuf_wr = 1'b1;
        do_cycle();
        sbuf_wr = 1'b0;
        n = 0;
        while (!(m_busy && m_cnt / m_div == 4 && m_cnt % m_div == 5) && n < 500) begin
            do_cycle();
            n++;
        end
        check("t5_in_bit3", txd, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_txd", txd, 1);
        check("t5_rst_ti", ti, 0);
        check("t5_rst_busy", tx_busy, 0);
        m_busy = 1'b0; m_ti = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sbuf_wdata = 8'h81; sbuf_wr = 1'b1;
        do_cycle();
        sbuf_wr = 1'b0;
        run_frame(1'b0, ti_at, idle_at);
        check("t5_ti_clk", ti_at, 145);

        // sm=0: write ignored
        sm = 2'd0; sbuf_wdata = 8'h12; sbuf_wr = 1'b1; clr_ti = 1'b1;
        do_cycle();
        sbuf_wr = 1'b0; clr_ti = 1'b0;
        for (int k = 0; k < 50; k++) do_cycle();
        check("t6_busy", tx_busy, 0);
        check("t6_txd", txd, 1);

        // Random traffic with mid-frame config changes, busy writes and clr_ti
        for (int c = 0; c < 12000; c++) begin
            if ($urandom_range(0, 63) == 0) begin
                sm   = 2'($urandom);
                smod = 1'($urandom);
                tb8  = 1'($urandom);
            end
            t_o        = 1'($urandom);
            sbuf_wdata = 8'($urandom);
            if (will_end())   sbuf_wr = 1'($urandom);
            else if (!m_busy) sbuf_wr = ($urandom_range(0, 7) == 0);
            else              sbuf_wr = ($urandom_range(0, 99) == 0);
            clr_ti = will_set() ? 1'($urandom) : ($urandom_range(0, 29) == 0);
            do_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
